// File: rtl/frame_line_streamer_pkg.sv
// Shared types and constants for the frame line streamer and its line-buffer peer.
package frame_line_streamer_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 8;
    localparam int DEFAULT_ADDR_WIDTH     = 11;
    localparam int DEFAULT_MEM_ADDR_WIDTH = 20;

    // The line buffer needs at least this many idle cycles to reset its column counter.
    localparam int HBLANK_MIN = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_BLANK,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // Bits needed to hold values 0..n (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/frame_line_streamer_if.sv
// Frame request, frame-memory read port and pixel-stream output bundle.
interface frame_line_streamer_if
    import frame_line_streamer_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int MEM_ADDR_WIDTH = DEFAULT_MEM_ADDR_WIDTH
);

    logic                      Start;
    logic [ADDR_WIDTH-1:0]     LineWidth;
    logic [ADDR_WIDTH-1:0]     LineCount;
    logic [MEM_ADDR_WIDTH-1:0] MemAddr;
    logic                      MemRdEn;
    logic [DATA_WIDTH-1:0]     MemData;
    logic                      DataEn;
    logic [DATA_WIDTH-1:0]     PixelData;
    logic                      LineStart;
    logic                      Busy;
    logic                      FrameDone;

    // Streamer side.
    modport master (
        input  Start, LineWidth, LineCount, MemData,
        output MemAddr, MemRdEn, DataEn, PixelData, LineStart, Busy, FrameDone
    );

    // Requester / memory / line-buffer side.
    modport slave (
        output Start, LineWidth, LineCount, MemData,
        input  MemAddr, MemRdEn, DataEn, PixelData, LineStart, Busy, FrameDone
    );

endinterface

// File: rtl/frame_line_streamer_pipe.sv
// Two-stage delay aligning the read/flush strobes with the memory read data.
module stream_pipe_reg
    import frame_line_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic                  flush_en,
    input  logic                  first,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  data_en,
    output logic [DATA_WIDTH-1:0] pixel,
    output logic                  line_start
);

    logic en_q;
    logic zero_q;
    logic first_q;

    // Stage 1: strobes wait out the one-cycle memory read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q    <= 1'b0;
            zero_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            en_q    <= rd_en | flush_en;
            zero_q  <= flush_en;
            first_q <= first;
        end
    end

    // Stage 2: register the pixel (zero for flush rows); hold it between bursts.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_en    <= 1'b0;
            line_start <= 1'b0;
            pixel      <= '0;
        end else begin
            data_en    <= en_q;
            line_start <= first_q;
            if (en_q) begin
                pixel <= zero_q ? '0 : mem_data;
            end
        end
    end

endmodule

// File: rtl/frame_line_streamer.sv
// Reads one frame in raster order and streams it as per-row DataEn bursts,
// separated by HBLANK idle cycles, followed by FLUSH_LINES zero rows.
module frame_line_streamer
    import frame_line_streamer_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int MEM_ADDR_WIDTH = DEFAULT_MEM_ADDR_WIDTH,
    parameter int HBLANK         = 4,
    parameter int FLUSH_LINES    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    frame_line_streamer_if.master bus
);

    if (HBLANK < HBLANK_MIN) begin : g_hblank_check
        $error("frame_line_streamer: HBLANK below the line-buffer minimum");
    end

    localparam int BLANK_W = cnt_width(HBLANK);
    localparam int FLUSH_W = cnt_width(FLUSH_LINES);

    localparam logic [BLANK_W-1:0]        BLANK_LAST = BLANK_W'(HBLANK - 1);
    localparam logic [BLANK_W-1:0]        BLANK_ONE  = BLANK_W'(1);
    localparam logic [FLUSH_W-1:0]        FLUSH_ROWS = FLUSH_W'(FLUSH_LINES);
    localparam logic [FLUSH_W-1:0]        FLUSH_ONE  = FLUSH_W'(1);
    localparam logic [ADDR_WIDTH-1:0]     ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [MEM_ADDR_WIDTH-1:0] MEM_ONE    = MEM_ADDR_WIDTH'(1);

    state_t                    state;
    logic [ADDR_WIDTH-1:0]     width;
    logic [ADDR_WIDTH-1:0]     height;
    logic [ADDR_WIDTH-1:0]     col;
    logic [ADDR_WIDTH-1:0]     row;
    logic                      image_done;
    logic [FLUSH_W-1:0]        flush_row;
    logic [BLANK_W-1:0]        blank_cnt;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic                      rd_en;
    logic                      flush_en;
    logic                      first;
    logic                      busy;
    logic                      frame_done;

    logic                      data_en;
    logic [DATA_WIDTH-1:0]     pixel;
    logic                      line_start;

    // Frame sequencing; BLANK starts on the cycle after the last strobe, so
    // with the fixed 2-cycle pipe the DataEn gap equals HBLANK exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            width      <= '0;
            height     <= '0;
            col        <= '0;
            row        <= '0;
            image_done <= 1'b0;
            flush_row  <= '0;
            blank_cnt  <= '0;
            mem_addr   <= '0;
            rd_en      <= 1'b0;
            flush_en   <= 1'b0;
            first      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            first      <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.Start) begin
                        width      <= bus.LineWidth;
                        height     <= bus.LineCount;
                        busy       <= 1'b1;
                        col        <= '0;
                        row        <= '0;
                        image_done <= 1'b0;
                        flush_row  <= '0;
                        blank_cnt  <= '0;
                        mem_addr   <= '0;
                        if (bus.LineWidth == '0 || bus.LineCount == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_READ;
                            rd_en <= 1'b1;
                            first <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    mem_addr <= mem_addr + MEM_ONE;
                    if (col == width - ADDR_ONE) begin
                        col   <= '0;
                        rd_en <= 1'b0;
                        state <= ST_BLANK;
                        if (row == height - ADDR_ONE) begin
                            image_done <= 1'b1;
                        end else begin
                            row <= row + ADDR_ONE;
                        end
                    end else begin
                        col <= col + ADDR_ONE;
                    end
                end
                ST_FLUSH: begin
                    if (col == width - ADDR_ONE) begin
                        col       <= '0;
                        flush_en  <= 1'b0;
                        flush_row <= flush_row + FLUSH_ONE;
                        state     <= ST_BLANK;
                    end else begin
                        col <= col + ADDR_ONE;
                    end
                end
                ST_BLANK: begin
                    if (blank_cnt == BLANK_LAST) begin
                        blank_cnt <= '0;
                        if (!image_done) begin
                            state <= ST_READ;
                            rd_en <= 1'b1;
                            first <= 1'b1;
                        end else if (flush_row != FLUSH_ROWS) begin
                            state    <= ST_FLUSH;
                            flush_en <= 1'b1;
                            first    <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                        end
                    end else begin
                        blank_cnt <= blank_cnt + BLANK_ONE;
                    end
                end
                ST_DONE: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    stream_pipe_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .flush_en  (flush_en),
        .first     (first),
        .mem_data  (bus.MemData),
        .data_en   (data_en),
        .pixel     (pixel),
        .line_start(line_start)
    );

    assign bus.MemAddr   = mem_addr;
    assign bus.MemRdEn   = rd_en;
    assign bus.DataEn    = data_en;
    assign bus.PixelData = pixel;
    assign bus.LineStart = line_start;
    assign bus.Busy      = busy;
    assign bus.FrameDone = frame_done;

endmodule

// File: tb/tb_frame_line_streamer.sv
// Scoreboard bench for frame_line_streamer: stimulus pushes expected beats and
// frame records; a negedge monitor pops and compares what the DUT emits.
module tb_frame_line_streamer;
    import frame_line_streamer_pkg::*;

    localparam int HB   = 4;
    localparam int FL   = 2;
    localparam int HB_B = 3;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    longint cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    frame_line_streamer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(11), .MEM_ADDR_WIDTH(20)) bus_a ();
    frame_line_streamer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(11), .MEM_ADDR_WIDTH(20)) bus_b ();

    frame_line_streamer #(
        .DATA_WIDTH(8), .ADDR_WIDTH(11), .MEM_ADDR_WIDTH(20), .HBLANK(HB), .FLUSH_LINES(FL)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );

    frame_line_streamer #(
        .DATA_WIDTH(8), .ADDR_WIDTH(11), .MEM_ADDR_WIDTH(20), .HBLANK(HB_B), .FLUSH_LINES(0)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    logic [7:0] mem [256];

    // Frame memories: data one cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        bus_a.MemData <= bus_a.MemRdEn ? mem[bus_a.MemAddr[7:0]] : 8'($urandom);
        bus_b.MemData <= bus_b.MemRdEn ? mem[bus_b.MemAddr[7:0]] : 8'($urandom);
    end

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { logic [7:0] pix; logic ls; longint at; } beat_t;
    typedef struct { int w; int h; longint acc; } frame_t;

    beat_t bq[$];
    frame_t fq[$];
    bit    mon_off       = 1'b0;
    int    rd_cnt        = 0;
    bit    first_rd_seen = 1'b0;
    bit    busy_err      = 1'b0;

    // Reference: row r (image or flush) starts 3 + r*(W+HB) cycles after the Start cycle.
    task automatic issue_frame(input int w, input int h, input bit hold);
        frame_t f;
        beat_t  b;
        bus_a.Start     = 1'b1;
        bus_a.LineWidth = 11'(w);
        bus_a.LineCount = 11'(h);
        f.w = w; f.h = h; f.acc = cyc;
        fq.push_back(f);
        if (w > 0 && h > 0) begin
            for (int r = 0; r < h + FL; r++) begin
                for (int c = 0; c < w; c++) begin
                    b.pix = (r < h) ? mem[8'(r * w + c)] : 8'h00;
                    b.ls  = (c == 0);
                    b.at  = f.acc + 3 + longint'(r * (w + HB) + c);
                    bq.push_back(b);
                end
            end
        end
        @(negedge clk);
        if (hold) begin
            bus_a.LineWidth = 11'd3;
            bus_a.LineCount = 11'd3;
            @(negedge clk);
        end
        bus_a.Start     = 1'b0;
        bus_a.LineWidth = 11'($urandom);
        bus_a.LineCount = 11'($urandom);
    endtask

    task automatic busy_start(input int w);
        check("busy_on_extra_start", bus_a.Busy, 1);
        bus_a.Start     = 1'b1;
        bus_a.LineWidth = 11'(w);
        bus_a.LineCount = 11'($urandom_range(1, 4));
        @(negedge clk);
        bus_a.Start     = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((fq.size() != 0 || bus_a.Busy) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("frame_finished_in_time", (n < limit) ? 1 : 0, 1);
    endtask

    // Monitor for dut_a.
    always @(negedge clk) begin
        beat_t  b;
        frame_t f;
        bit     empty;
        if (!mon_off && !rst) begin
            if (bus_a.DataEn) begin
                check("beat_expected", (bq.size() != 0) ? 1 : 0, 1);
                if (bq.size() != 0) begin
                    b = bq.pop_front();
                    check("pixel", bus_a.PixelData, b.pix);
                    check("linestart", bus_a.LineStart, b.ls);
                    check("beat_cycle", cyc, b.at);
                end
            end
            if (bus_a.LineStart) check("linestart_has_dataen", bus_a.DataEn, 1);
            if (bus_a.MemRdEn) begin
                if (!first_rd_seen && fq.size() != 0) check("first_read_cycle", cyc, fq[0].acc + 1);
                first_rd_seen = 1'b1;
                rd_cnt++;
            end
            if (fq.size() != 0 && cyc > fq[0].acc && !bus_a.FrameDone && !bus_a.Busy) busy_err = 1'b1;
            if (bus_a.FrameDone) begin
                check("frame_expected", (fq.size() != 0) ? 1 : 0, 1);
                if (fq.size() != 0) begin
                    f = fq.pop_front();
                    empty = (f.w == 0 || f.h == 0);
                    check("done_cycle", cyc - f.acc, empty ? 2 : longint'((f.h + FL) * (f.w + HB) + 2));
                    check("read_count", rd_cnt, f.w * f.h);
                    check("busy_at_done", bus_a.Busy, 0);
                    check("busy_held", busy_err, 0);
                    check("beats_left", bq.size(), 0);
                end
                rd_cnt        = 0;
                first_rd_seen = 1'b0;
                busy_err      = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", compared);
        $fatal(1, "watchdog");
    end

    initial begin
        int     n;
        int     w;
        int     h;
        longint target;
        longint acc_b;
        longint de_cyc;
        longint done_cyc;
        int     de_n;
        int     rd_n;
        logic [7:0] pix_b;
        logic       ls_b;

        bus_a.Start = 1'b0; bus_a.LineWidth = '0; bus_a.LineCount = '0;
        bus_b.Start = 1'b0; bus_b.LineWidth = '0; bus_b.LineCount = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dataen", bus_a.DataEn, 0);
        check("rst_memrden", bus_a.MemRdEn, 0);
        check("rst_memaddr", bus_a.MemAddr, 0);
        check("rst_pixel", bus_a.PixelData, 0);
        check("rst_linestart", bus_a.LineStart, 0);
        check("rst_busy", bus_a.Busy, 0);
        check("rst_framedone", bus_a.FrameDone, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic frame, identity memory.
        issue_frame(4, 3, 1'b0);
        wait_idle(500);

        // Same frame with a W=7 Start while busy: output must be unchanged.
        issue_frame(4, 3, 1'b0);
        repeat (10) @(negedge clk);
        busy_start(7);
        wait_idle(500);

        // Zero sizes; the first holds Start into the DONE cycle, which must be ignored.
        issue_frame(0, 5, 1'b1);
        wait_idle(50);
        issue_frame(6, 0, 1'b0);
        wait_idle(50);

        // Mid-frame reset on row 1, pixel 5.
        issue_frame(8, 3, 1'b0);
        target = fq[0].acc + 3 + (8 + HB) + 5;
        while (cyc < target) @(negedge clk);
        mon_off = 1'b1;
        rst     = 1'b1;
        @(negedge clk);
        check("midrst_dataen", bus_a.DataEn, 0);
        check("midrst_memrden", bus_a.MemRdEn, 0);
        check("midrst_memaddr", bus_a.MemAddr, 0);
        check("midrst_pixel", bus_a.PixelData, 0);
        check("midrst_linestart", bus_a.LineStart, 0);
        check("midrst_busy", bus_a.Busy, 0);
        check("midrst_framedone", bus_a.FrameDone, 0);
        rst = 1'b0;
        bq.delete();
        fq.delete();
        rd_cnt = 0; first_rd_seen = 1'b0; busy_err = 1'b0;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus_a.DataEn || bus_a.MemRdEn) n++;
        end
        check("activity_after_reset", n, 0);
        mon_off = 1'b0;
        issue_frame(2, 1, 1'b0);
        wait_idle(200);

        // Randomised frames over random memory contents.
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int k = 0; k < 14; k++) begin
            w = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 10));
            h = $urandom_range(1, 5);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue_frame(w, h, 1'b0);
            if (w > 0 && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, w + HB)) @(negedge clk);
                busy_start($urandom_range(1, 12));
            end
            wait_idle(2000);
        end

        // Minimum sizes on the HBLANK=3, no-flush instance.
        mem[0] = 8'($urandom) | 8'h01;
        bus_b.Start = 1'b1; bus_b.LineWidth = 11'd1; bus_b.LineCount = 11'd1;
        acc_b = cyc;
        @(negedge clk);
        bus_b.Start = 1'b0;
        de_n = 0; rd_n = 0; de_cyc = -1; done_cyc = -1; pix_b = '0; ls_b = 1'b0;
        repeat (30) begin
            if (bus_b.DataEn) begin
                de_n++;
                de_cyc = cyc;
                pix_b  = bus_b.PixelData;
                ls_b   = bus_b.LineStart;
            end
            if (bus_b.MemRdEn) rd_n++;
            if (bus_b.FrameDone) done_cyc = cyc;
            @(negedge clk);
        end
        check("min_dataen_count", de_n, 1);
        check("min_read_count", rd_n, 1);
        check("min_pixel", pix_b, mem[0]);
        check("min_linestart", ls_b, 1);
        check("min_first_dataen_cycle", de_cyc, acc_b + 3);
        check("min_done_after_dataen", done_cyc - de_cyc, HB_B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/frame_line_streamer.md
Name: frame_line_streamer

Overview:
- Transmit side of the pixel-stream interface consumed by the line buffer, i.e. the `DataEn`/`PixelData` pair.
- On a start pulse it reads one frame from a single-port frame memory, raster order.
- Each image row is emitted as one contiguous `DataEn` burst, separated by a programmable horizontal blank. The line buffer relies on that gap to reset its column counter.
- After the last image row it emits `FLUSH_LINES` zero-valued rows, so the downstream window operator outputs the bottom rows of the image.

Parameters:
- `DATA_WIDTH`, 8: pixel bit width.
- `ADDR_WIDTH`, 11: column/row counter width; max width and height = 2^ADDR_WIDTH - 1.
- `MEM_ADDR_WIDTH`, 20: frame memory address width.
- `HBLANK`, 4: idle cycles between bursts; legal range ≥ 3, elaboration-time error otherwise.
- `FLUSH_LINES`, 2: zero rows appended after the image; set to operator height - 1.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `Start`, in, 1: single-cycle frame request; ignored unless `Busy` = 0.
- `LineWidth`, in, `ADDR_WIDTH`: pixels per row, latched on accepted `Start`.
- `LineCount`, in, `ADDR_WIDTH`: image rows, latched on accepted `Start`.
- `MemAddr`, out, `MEM_ADDR_WIDTH`: frame memory read address, linear, base 0.
- `MemRdEn`, out, 1: read strobe; `MemData` is valid exactly 1 cycle later.
- `MemData`, in, `DATA_WIDTH`: frame memory read data.
- `DataEn`, out, 1: pixel valid, one burst per row.
- `PixelData`, out, `DATA_WIDTH`: registered pixel.
- `LineStart`, out, 1: pulse coincident with the first `DataEn` cycle of every row, flush rows included.
- `Busy`, out, 1: high from accepted `Start` until `FrameDone`.
- `FrameDone`, out, 1: single-cycle pulse after the final burst and its trailing blank.

Behaviour:
- Reset:
  - All outputs are 0, FSM = IDLE, counters = 0.
  - `rst` mid-frame forces this state on the next edge. The in-flight read is discarded and no further `DataEn` appears.
- FSM states: IDLE, READ, BLANK, FLUSH, DONE.
- IDLE: on `Start`, latch `LineWidth`/`LineCount` and set `Busy`.
  - If either value = 0, go to DONE with no `DataEn` at all.
  - Otherwise go to READ with col = 0, row = 0, addr = 0.
- READ:
  - `MemRdEn` = 1 for exactly W consecutive cycles; `MemAddr` increments by 1 each cycle.
  - After the W-th read, go to BLANK.
  - Address is a running counter; no multiplier. The counter continues across rows, so row r starts at r*W.
- Data pipeline:
  - `MemRdEn` at cycle t means `MemData` at t+1, registered into `PixelData`.
  - `DataEn` goes high at t+2, so fixed latency from strobe to `DataEn` is 2 cycles.
  - `PixelData` holds its last value when `DataEn` = 0; when reading, the held value must not be checked.
- BLANK:
  - Counts `HBLANK` cycles measured from the last `DataEn` cycle, so the bus gap is exactly `HBLANK` cycles of `DataEn` = 0.
  - Then: next image row → READ; all image rows done and `FLUSH_LINES` > 0 → FLUSH; otherwise → DONE.
- FLUSH:
  - Emits W cycles of `DataEn` = 1 with `PixelData` = 0, and `MemRdEn` = 0.
  - Timing is aligned so the gap rule (`HBLANK`) holds identically.
  - Returns to BLANK; after `FLUSH_LINES` rows it proceeds to DONE via the final BLANK.
- DONE: `FrameDone` = 1 for one cycle, `Busy` = 0 in the same cycle, then IDLE. A `Start` in the DONE cycle is ignored.
- Per-frame totals:
  - Bursts: H + `FLUSH_LINES`.
  - `DataEn` cycles: W·(H + `FLUSH_LINES`).
  - `MemRdEn` cycles: W·H.
- Boundaries:
  - W = 1: bursts 1 cycle long.
  - Max W/H (all ones): counters must not wrap early. Address width overflow is the integrator's responsibility.
  - `Start` while `Busy`: ignored, with no effect on the latched sizes.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE/READ/BLANK/FLUSH/DONE).
  - `HBLANK_MIN` = 3, the line-buffer counter-reset requirement.
  - Default `DATA_WIDTH`/`ADDR_WIDTH` constants shared with the line buffer.
- One natural sub-module: `stream_pipe_reg`. It is the 2-stage enable/data delay aligning `MemRdEn` to `DataEn`/`PixelData`, and zero-forcing for flush rows.

Test Plan:
- Basic frame:
  - Stimulus: W=4, H=3, `HBLANK`=4, `FLUSH_LINES`=2, memory[i]=i.
  - Required: 5 bursts of 4.
  - Pixels: 0,1,2,3 | 4,5,6,7 | 8,9,10,11 | 0,0,0,0 | 0,0,0,0.
  - Gaps exactly 4 cycles.
  - `FrameDone` 4 cycles after the last `DataEn`; first `DataEn` 2 cycles after the first `MemRdEn`.
- Zero size:
  - Stimulus: W=0, H=5.
  - Required: `Busy` pulses, `FrameDone` 2 cycles after `Start`, zero `DataEn` and zero `MemRdEn`.
- Start while busy:
  - Stimulus: second `Start` with W=7 during the W=4 frame above.
  - Required: output identical to the basic-frame case, and `Busy` stays high.
- Mid-frame reset:
  - Stimulus: `rst` during row 1, pixel 5.
  - Required: all outputs 0 next cycle, no further `DataEn`.
  - A following `Start` (W=2, H=1) emits 0,1 then 0,0 ×2.
- End-to-end with line buffer:
  - Stimulus: W=8, H=4, 3-row operator.
  - Required: line buffer `addrb` starts at 0 on every row (no counter carry-over).
  - `OperatorData` top slice equals row r while the lower slices equal rows r-1 and r-2.
- Minimum sizes:
  - Stimulus: W=1, H=1, `FLUSH_LINES`=0, `HBLANK`=3.
  - Required: exactly one `DataEn` with `PixelData`=mem[0], and `FrameDone` 3 cycles later.
